// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite S00_AXI channel bundle between the block-design master and the register slave.
interface axi_lite_reg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers, mirrored on reg_out.
// Define AXI_LITE_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axi_lite_reg_slave #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  axi_lite_reg_slave_if.slave    s00_axi,
  output logic [32*NUM_REGS-1:0] reg_out
);
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;

  if (NUM_REGS < 1 || NUM_REGS > 16 || ADDR_WIDTH < 3 || ADDR_WIDTH < $clog2(NUM_REGS) + 2)
  begin : g_param_check
    $error("axi_lite_reg_slave: unsupported NUM_REGS/ADDR_WIDTH combination");
  end

  logic [0:0]       state_q, state_n;
  logic             ready_en_q;
  logic             aw_held_q, aw_held_n;
  logic             w_held_q, w_held_n;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_n;
  logic [31:0]      wdata_q, wdata_n;
  logic [3:0]       wstrb_q, wstrb_n;
  logic             bvalid_q, bvalid_n;
  logic [1:0]       bresp_q, bresp_n;
  logic             commit;

  logic             rvalid_q, rvalid_n;
  logic [31:0]      rdata_q, rdata_n;
  logic [1:0]       rresp_q, rresp_n;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_val;

  logic [31:0]      regs_q [NUM_REGS];

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs;

  // Ready terms are pure functions of flops, so they never depend on the master's valids.
  assign awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign wready  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign arready = ready_en_q & ~rvalid_q;

  assign aw_hs  = s00_axi.S_AXI_AWVALID & awready;
  assign w_hs   = s00_axi.S_AXI_WVALID & wready;
  assign ar_hs  = s00_axi.S_AXI_ARVALID & arready;
  assign ar_idx = s00_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];

  assign s00_axi.S_AXI_AWREADY = awready;
  assign s00_axi.S_AXI_WREADY  = wready;
  assign s00_axi.S_AXI_ARREADY = arready;
  assign s00_axi.S_AXI_BVALID  = bvalid_q;
  assign s00_axi.S_AXI_BRESP   = bresp_q;
  assign s00_axi.S_AXI_RVALID  = rvalid_q;
  assign s00_axi.S_AXI_RDATA   = rdata_q;
  assign s00_axi.S_AXI_RRESP   = rresp_q;

  logic unused_bits;
  assign unused_bits = ^{s00_axi.S_AXI_AWPROT, s00_axi.S_AXI_ARPROT,
                         s00_axi.S_AXI_AWADDR[1:0], s00_axi.S_AXI_ARADDR[1:0]};

  // Write path: collect AW and W in any order, commit when both are present.
  always_comb begin
    state_n   = state_q;
    aw_held_n = aw_held_q;
    w_held_n  = w_held_q;
    aw_idx_n  = aw_idx_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    commit    = 1'b0;

    if (aw_hs) aw_idx_n = s00_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    if (w_hs) begin
      wdata_n = s00_axi.S_AXI_WDATA;
      wstrb_n = s00_axi.S_AXI_WSTRB;
    end

    case (state_q)
      W_COLLECT: begin
        aw_held_n = aw_held_q | aw_hs;
        w_held_n  = w_held_q | w_hs;
        if (aw_held_n && w_held_n) begin
          commit    = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = (32'(aw_idx_n) < NUM_REGS) ? RESP_OKAY : RESP_UNMAPPED;
          state_n   = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi.S_AXI_BREADY) begin
          bvalid_n = 1'b0;
          state_n  = W_COLLECT;
        end
      end
      default: state_n = W_COLLECT;
    endcase
  end

  // Read mux over the current (pre-commit) register contents.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) rd_val = regs_q[k];
    end
  end

  // Read path: a single outstanding response, held until RREADY.
  always_comb begin
    rvalid_n = rvalid_q;
    rdata_n  = rdata_q;
    rresp_n  = rresp_q;
    if (rvalid_q) begin
      if (s00_axi.S_AXI_RREADY) rvalid_n = 1'b0;
    end else if (ar_hs) begin
      rvalid_n = 1'b1;
      rdata_n  = rd_val;
      rresp_n  = (32'(ar_idx) < NUM_REGS) ? RESP_OKAY : RESP_UNMAPPED;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= W_COLLECT;
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_n;
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_n;
      w_held_q   <= w_held_n;
      aw_idx_q   <= aw_idx_n;
      wdata_q    <= wdata_n;
      wstrb_q    <= wstrb_n;
      bvalid_q   <= bvalid_n;
      bresp_q    <= bresp_n;
      rvalid_q   <= rvalid_n;
      rdata_q    <= rdata_n;
      rresp_q    <= rresp_n;
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (commit && aw_idx_n == IDX_W'(k) && wstrb_n[b])
            regs_q[k][8*b +: 8] <= wdata_n[8*b +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end
endmodule
